// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, FSM states and helpers for the data memory responder
package mem_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Misalignment or unknown width code; range is checked by the core.
   function automatic logic access_err(input logic [1:0] off, input logic [2:0] ctrl);
      case (ctrl)
         CTRL_B, CTRL_BU: return 1'b0;
         CTRL_H, CTRL_HU: return off[0];
         CTRL_W:          return (off != 2'b00);
         default:         return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_en(input logic [1:0] off, input logic [2:0] ctrl);
      case (ctrl)
         CTRL_B, CTRL_BU: return 4'b0001 << off;
         CTRL_H, CTRL_HU: return off[1] ? 4'b1100 : 4'b0011;
         CTRL_W:          return 4'b1111;
         default:         return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between initiator and memory responder
interface data_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_ctrl;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_ctrl, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_ctrl, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half lane of a word and sign/zero extends it
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_ctrl,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[{i_off, 3'b000} +: 8];
      w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
      case (i_ctrl)
         CTRL_B:  o_data = {{24{w_byte[7]}}, w_byte};
         CTRL_H:  o_data = {{16{w_half[15]}}, w_half};
         CTRL_BU: o_data = {24'd0, w_byte};
         CTRL_HU: o_data = {16'd0, w_half};
         CTRL_W:  o_data = i_word;
         default: o_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding word memory with fixed-latency load/store responses
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);

   localparam int               IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [1:0]       r_off;
   logic [2:0]       r_ctrl;
   logic             r_write;
   logic             r_err;
   logic [31:0]      r_rdata;
   logic             r_rsp_err;
   logic [31:0]      r_mem [DEPTH_WORDS];

   logic             w_accept;
   logic             w_req_err;
   logic [IDX_W-1:0] w_idx;
   logic [3:0]       w_lane_en;
   logic [31:0]      w_wdata_rep;
   logic [31:0]      w_rd_word;
   logic [31:0]      w_load_data;

   assign w_idx     = bus.req_addr[IDX_W+1:2];
   assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
   assign w_req_err = access_err(bus.req_addr[1:0], bus.req_ctrl) ||
                      (bus.req_addr[31:2] >= DEPTH_LIM);
   assign w_lane_en = lane_en(bus.req_addr[1:0], bus.req_ctrl);
   assign w_rd_word = r_mem[r_idx];

   always_comb begin
      w_wdata_rep = bus.req_wdata;
      case (bus.req_ctrl)
         CTRL_B, CTRL_BU: w_wdata_rep = {4{bus.req_wdata[7:0]}};
         CTRL_H, CTRL_HU: w_wdata_rep = {2{bus.req_wdata[15:0]}};
         default:         w_wdata_rep = bus.req_wdata;
      endcase
   end

   // Stores commit at acceptance; storage is intentionally outside the reset domain.
   always_ff @(posedge clk) begin
      if (reset && w_accept && bus.req_write && !w_req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_lane_en[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
         end
      end
   end

   load_extend u_load_extend (
      .i_word (w_rd_word),
      .i_off  (r_off),
      .i_ctrl (r_ctrl),
      .o_data (w_load_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_off     <= '0;
         r_ctrl    <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_idx   <= w_idx;
            r_off   <= bus.req_addr[1:0];
            r_ctrl  <= bus.req_ctrl;
            r_write <= bus.req_write;
            r_err   <= w_req_err;
            r_cnt   <= CNT_LOAD;
         end else if (r_state == ST_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (r_state == ST_BUSY && r_cnt == '0) begin
            r_rdata   <= (r_write || r_err) ? 32'd0 : w_load_data;
            r_rsp_err <= r_err;
         end else if (r_state == ST_RESP && bus.rsp_ready) begin
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.req_valid) w_next = ST_BUSY;
         ST_BUSY: if (r_cnt == '0)   w_next = ST_RESP;
         ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign bus.req_ready = (r_state == ST_IDLE);
   assign bus.rsp_valid = (r_state == ST_RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench against a byte-array memory model
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [7:0] ref_mem [0:4*DEPTH-1];

   data_mem_responder_if if0 ();
   data_mem_responder_if if1 ();

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (if0.slave)
   );

   data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut_l1 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (if1.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Little-endian byte memory; widths and legality from the access rules.
   function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] c, output logic [31:0] rd, output logic e);
      int  sz;
      bit  legal;
      legal = (c == 3'd0 || c == 3'd1 || c == 3'd2 || c == 3'd4 || c == 3'd5);
      sz    = (c == 3'd2) ? 4 : ((c == 3'd1 || c == 3'd5) ? 2 : 1);
      e     = !legal || (a % sz != 0) || (a / 4 >= DEPTH);
      rd    = 32'd0;
      if (!e) begin
         for (int k = 0; k < sz; k++) begin
            if (w) ref_mem[int'(a) + k] = d[8*k +: 8];
            else   rd = rd | ({24'd0, ref_mem[int'(a) + k]} << (8 * k));
         end
         if (!w && c == 3'd0 && rd[7])  rd = rd | 32'hFFFF_FF00;
         if (!w && c == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
      end
   endfunction

   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c, input int hold, output logic [31:0] got);
      logic [31:0] exp_rd;
      logic        exp_e;
      logic [31:0] held;
      int          t;
      int          lat;
      model(w, a, d, c, exp_rd, exp_e);
      @(negedge clk);
      if0.req_valid = 1'b1;
      if0.req_write = w;
      if0.req_addr  = a;
      if0.req_wdata = d;
      if0.req_ctrl  = c;
      t = 0;
      while (!if0.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("req_ready", 32'(if0.req_ready), 32'd1);
      @(posedge clk);
      #1;
      // Junk on the request side must be ignored while the request is outstanding.
      if0.req_valid = 1'($urandom);
      if0.req_write = 1'($urandom);
      if0.req_addr  = $urandom;
      if0.req_wdata = $urandom;
      if0.req_ctrl  = 3'($urandom);
      lat = 0;
      while (!if0.rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(LAT));
      check("rdata", if0.rsp_rdata, exp_rd);
      check("err", 32'(if0.rsp_err), 32'(exp_e));
      got  = if0.rsp_rdata;
      held = if0.rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(if0.rsp_valid), 32'd1);
         check("hold_rdata", if0.rsp_rdata, held);
         check("hold_ready", 32'(if0.req_ready), 32'd0);
      end
      if0.req_valid = 1'b0;
      if0.rsp_ready = 1'b1;
      check("hs_ready", 32'(if0.req_ready), 32'd0);
      @(posedge clk);
      #1;
      if0.rsp_ready = 1'b0;
      check("post_ready", 32'(if0.req_ready), 32'd1);
      check("post_valid", 32'(if0.rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      int          prev;
      int          t;
      int          nresp;
      if0.req_valid = 0; if0.req_write = 0; if0.req_addr = 0; if0.req_wdata = 0;
      if0.req_ctrl  = 0; if0.rsp_ready = 0;
      if1.req_valid = 0; if1.req_write = 0; if1.req_addr = 0; if1.req_wdata = 0;
      if1.req_ctrl  = 0; if1.rsp_ready = 0;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(if0.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
      check("rst_rsp_rdata", if0.rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(if0.rsp_err), 32'd0);
      rst_n = 1'b1;

      txn(1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, got);
      txn(0, 32'h10, 32'h0, 3'b010, 0, got);
      check("word_rd", got, 32'hDEAD_BEEF);
      txn(1, 32'h11, 32'h80, 3'b000, 0, got);
      txn(0, 32'h11, 32'h0, 3'b000, 1, got);
      check("byte_signed", got, 32'hFFFF_FF80);
      txn(0, 32'h11, 32'h0, 3'b100, 0, got);
      check("byte_unsigned", got, 32'h0000_0080);
      txn(0, 32'h10, 32'h0, 3'b010, 0, got);
      check("byte_merge", got, 32'hDEAD_80EF);
      txn(0, 32'h13, 32'h0, 3'b001, 0, got);
      txn(1, 32'h12, 32'h5555_5555, 3'b010, 2, got);
      txn(0, 32'h10, 32'h0, 3'b010, 5, got);
      check("err_no_write", got, 32'hDEAD_80EF);

      // Reset while a load is in BUSY: no response afterward, prior store retained.
      txn(1, 32'h20, 32'hCAFE_F00D, 3'b010, 0, got);
      @(negedge clk);
      if0.req_valid = 1; if0.req_write = 0; if0.req_addr = 32'h20; if0.req_ctrl = 3'b010;
      @(posedge clk);
      #1;
      if0.req_valid = 0;
      check("abort_busy", 32'(if0.req_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(if0.rsp_valid), 32'd0);
      check("abort_ready", 32'(if0.req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("abort_norsp", 32'(if0.rsp_valid), 32'd0);
      end
      txn(0, 32'h20, 32'h0, 3'b010, 0, got);
      check("abort_store_kept", got, 32'hCAFE_F00D);

      for (int i = 0; i < DEPTH; i++) txn(1, 32'(4 * i), 32'h0, 3'b010, 0, got);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 4095);
         else                           a = $urandom_range(0, 4 * DEPTH - 1);
         txn(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), got);
      end

      // LATENCY=1 instance: store then back-to-back loads with rsp_ready held high.
      @(negedge clk);
      if1.rsp_ready = 1; if1.req_valid = 1; if1.req_write = 1;
      if1.req_addr = 32'h4; if1.req_wdata = 32'h1234_5678; if1.req_ctrl = 3'b010;
      prev  = 0;
      nresp = 0;
      for (int k = 0; k < 5; k++) begin
         t = 0;
         while (!if1.req_ready && t < 10) begin
            if (if1.rsp_valid) begin
               check("l1_rdata", if1.rsp_rdata, (nresp == 0) ? 32'h0 : 32'h1234_5678);
               nresp++;
            end
            @(negedge clk);
            t++;
         end
         check("l1_ready", 32'(if1.req_ready), 32'd1);
         if (k > 0) check("l1_spacing", 32'(cyc - prev), 32'd3);
         prev = cyc;
         @(posedge clk);
         #1;
         if1.req_write = 0;
         @(negedge clk);
      end
      if1.req_valid = 0;
      repeat (4) @(negedge clk);
      if1.rsp_ready = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to rsp_valid (legal range 1 to 15).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  the initiator presents a request.
REQ-006 req_ready  output  1  the responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ctrl  input  3  width/sign code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-011 rsp_valid  output  1  a response is presented.
REQ-012 rsp_ready  input  1  the initiator accepts the response.
REQ-013 rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  the request was misaligned, out of range, or used an illegal req_ctrl.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, so at most one request is outstanding.
REQ-017 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; on acceptance, the block latches addr, ctrl and write, loads the counter with LATENCY-1, and moves to BUSY.
REQ-018 In BUSY, the counter SHALL decrement each cycle; at 0 the block captures the read data into the response register and moves to RESP.
REQ-019 With LATENCY=1, the block SHALL go IDLE to BUSY to RESP, with rsp_valid high exactly 1 cycle after acceptance; in general, rsp_valid rises LATENCY cycles after the acceptance edge.
REQ-020 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid and rsp_ready are both 1; on that edge, the block returns to IDLE.
REQ-021 req_ready SHALL NOT rise in the same cycle as the response handshake; it rises 1 cycle later.
REQ-022 A store SHALL commit at the acceptance edge, writing only the addressed bytes: the byte lane selected by addr[1:0] for byte stores, lanes {addr[1],0} and {addr[1],1} for half stores, and all lanes for word stores.
REQ-023 Because stores commit at acceptance, a load accepted after a store's response SHALL return the stored value.
REQ-024 Loads SHALL extract the addressed lane; codes 000 and 001 sign-extend, and codes 100, 101 and 010 zero-extend or pass through.
REQ-025 A half access with addr[0]=1, a word access with addr[1:0]≠0, a word index at or above DEPTH_WORDS, or a req_ctrl not listed in REQ-010 SHALL set rsp_err=1.
REQ-026 An errored store SHALL NOT modify memory, and every errored response SHALL return rsp_rdata=0; errors still complete the full handshake with normal latency.
REQ-027 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; no address wrap-around is permitted (see the out-of-range rule in REQ-025).
REQ-028 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-029 While reset=0, the block SHALL be in state IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the counter at 0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately; a store already accepted remains committed, and no response is issued afterward.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package mem_pkg SHALL hold the req_ctrl encodings, the FSM state enum and the LATENCY counter width.
REQ-033 Load lane extraction and sign/zero extension SHALL be a combinational sub-module named load_extend, reused by the core's writeback path.

Verification
REQ-034 Reset release, then a word store of 0xDEADBEEF to 0x10 followed by a word load from 0x10: the load returns rsp_rdata=0xDEADBEEF with rsp_err=0, and rsp_valid rises 2 cycles after each acceptance.
REQ-035 Byte store 0x80 to 0x11, then a load with code 000 from 0x11 returns 0xFFFFFF80, code 100 returns 0x00000080, and a word load from 0x10 returns 0xDEAD80EF.
REQ-036 Half load from 0x13 and word store to 0x12 both return rsp_err=1 and rsp_rdata=0, and a subsequent word load from 0x10 is unchanged.
REQ-037 Holding rsp_ready=0 for 5 cycles in RESP keeps rsp_valid and rsp_rdata stable and req_ready=0; req_ready rises 1 cycle after the handshake.
REQ-038 Asserting reset in BUSY during a load drops rsp_valid and sets req_ready=1 with no response after reset release; a store to 0x20 accepted before that reset reads back correctly.
REQ-039 With LATENCY=1, back-to-back loads under rsp_ready=1 run at one transaction per 3 cycles.
